// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its on-chip sequencer/checker:
// opcode map, sequencer state encoding and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_checker_if.sv
// Operand/opcode bus from the sequencer to the ALU and the ALU's response.
// The sequencer is the master; the ALU under test is the slave.
interface alu_seq_checker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_s;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;

    modport master (
        output alu_a, alu_b, alu_s,
        input  alu_y, alu_carry
    );

    modport slave (
        input  alu_a, alu_b, alu_s,
        output alu_y, alu_carry
    );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU: expected {carry, y} for (a, b, s).
// Logic opcodes always expect carry = 0.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The borrow out of the widened subtraction is exactly a < b.
    assign diff = {1'b0, a} - {1'b0, b};

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (s)
            OP_ADD: begin y = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
            OP_SUB: begin y = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin y = {a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
            OP_SHR: begin y = {1'b0, a[WIDTH-1:1]}; carry = a[0];       end
            default: begin y = '0; carry = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_seq_checker.sv
// ALU self-test engine: on start, walks one operand pair through all eight
// opcodes, holds each for DWELL cycles, and checks the response per opcode.
module alu_seq_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DWELL = 10,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    alu_seq_checker_if.master  alu,
    output logic               busy,
    output logic               done,
    output logic [7:0]         err_mask,
    output logic               pass
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [2:0]       s_q, s_n;
    logic             busy_n, done_n, pass_n;
    logic [7:0]       mask_n;
    logic [WIDTH-1:0] exp_y;
    logic             exp_c;
    logic             mismatch;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a     (a_q),
        .b     (b_q),
        .s     (s_q),
        .y     (exp_y),
        .carry (exp_c)
    );

    assign alu.alu_a = a_q;
    assign alu.alu_b = b_q;
    assign alu.alu_s = s_q;

    // Written as "equal -> ok, else fail" so an unknown response lands on the
    // failing branch instead of silently passing.
    always_comb begin
        if ({alu.alu_carry, alu.alu_y} == {exp_c, exp_y}) mismatch = 1'b0;
        else                                              mismatch = 1'b1;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        s_n     = s_q;
        busy_n  = busy;
        done_n  = 1'b0;
        mask_n  = err_mask;
        pass_n  = pass;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_n     = a_in;
                    b_n     = b_in;
                    s_n     = OP_ADD;
                    mask_n  = '0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_DRIVE;
                end
            end
            // DWELL-1 drive cycles plus the sample cycle hold each opcode DWELL cycles.
            ST_DRIVE: begin
                if (cnt == CNT_W'(DWELL - 2)) begin
                    cnt_n   = '0;
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                // NOTE: blocking assignments in always_comb make the updated
                // mask visible to the pass computation on the next line.
                if (mismatch) mask_n[s_q] = 1'b1;
                if (s_q == OP_SHR) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (mask_n == '0);
                    state_n = ST_DONE;
                end else begin
                    s_n     = s_q + 3'd1;
                    cnt_n   = '0;
                    state_n = ST_DRIVE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_mask <= '0;
            pass     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            a_q      <= a_n;
            b_q      <= b_n;
            s_q      <= s_n;
            busy     <= busy_n;
            done     <= done_n;
            err_mask <= mask_n;
            pass     <= pass_n;
        end
    end

endmodule

// File: tb/tb_alu_seq_checker.sv
// Randomised self-checking bench: a behavioural ALU with fault injection
// answers the sequencer, and an arithmetic model predicts masks and timing.
module tb_alu_seq_checker;

    localparam int D = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in, b_in;
    logic       busy, done, pass;
    logic [7:0] err_mask;

    int checks   = 0;
    int failures = 0;
    int fault_mode;
    int fault_op;

    alu_seq_checker_if #(.WIDTH(8)) bus ();

    alu_seq_checker #(.WIDTH(8), .DWELL(D), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .alu      (bus),
        .busy     (busy),
        .done     (done),
        .err_mask (err_mask),
        .pass     (pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Opcode behaviour from the ALU datasheet, in plain integer arithmetic.
    function automatic logic [8:0] alu_model(input int a, input int b, input int s);
        int y = 0;
        int c = 0;
        case (s)
            0: begin y = a + b; c = (y > 255) ? 1 : 0; y = y % 256; end
            1: begin c = (a < b) ? 1 : 0; y = (a - b + 256) % 256; end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = 255 - a;
            6: begin y = (a * 2) % 256; c = a / 128; end
            default: begin y = a / 2; c = a % 2; end
        endcase
        return {c[0], y[7:0]};
    endfunction

    // Fault modes: 1 y stuck at 0, 2 carry inverted, 3 y bit0 inverted.
    function automatic logic [8:0] apply_fault(input logic [8:0] r, input int s);
        logic [8:0] f = r;
        if (fault_mode != 0 && s == fault_op) begin
            case (fault_mode)
                1:       f[7:0] = 8'h00;
                2:       f[8]   = ~f[8];
                default: f[0]   = ~f[0];
            endcase
        end
        return f;
    endfunction

    always_comb begin
        logic [8:0] r;
        r = apply_fault(alu_model(int'(bus.alu_a), int'(bus.alu_b), int'(bus.alu_s)),
                        int'(bus.alu_s));
        bus.alu_y     = r[7:0];
        bus.alu_carry = r[8];
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 0);
        check({tag, "_alu_s"}, 32'(bus.alu_s), 0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_done"},  32'(done),      0);
        check({tag, "_mask"},  32'(err_mask),  0);
        check({tag, "_pass"},  32'(pass),      0);
    endtask

    // One complete run; xs > 0 re-pulses start (with new operands) at that cycle.
    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input int xs, input string tag);
        logic [7:0] exp_mask = '0;
        int done_cnt = 0;
        int done_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            logic [8:0] good;
            good = alu_model(int'(a), int'(b), k);
            if (apply_fault(good, k) != good) exp_mask[k] = 1'b1;
        end
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int cyc = 1; cyc <= 8 * D + 15; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                start = 1'b0;
                check({tag, "_cap_a"}, 32'(bus.alu_a), 32'(a));
                check({tag, "_cap_b"}, 32'(bus.alu_b), 32'(b));
                check({tag, "_busy"},  32'(busy), 1);
                check({tag, "_clr"},   32'({pass, err_mask}), 0);
            end
            if (cyc == 2) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
            if (xs > 0 && cyc == xs) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = ~b;
            end
            if (xs > 0 && cyc == xs + 1) start = 1'b0;
            if (cyc <= 8 * D && ((cyc - 1) % D == 0 || cyc % D == 0))
                check({tag, "_alu_s"}, 32'(bus.alu_s), (cyc - 1) / D);
            if (cyc == 8 * D) begin
                check({tag, "_hold_a"}, 32'(bus.alu_a), 32'(a));
                check({tag, "_hold_b"}, 32'(bus.alu_b), 32'(b));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 8 * D + 1) begin
                check({tag, "_end_busy"}, 32'(busy), 0);
                check({tag, "_mask"}, 32'(err_mask), 32'(exp_mask));
                check({tag, "_pass"}, 32'(pass), 32'(exp_mask == 8'h00));
            end
        end
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(8 * D + 1));
        check({tag, "_done_cnt"}, 32'(done_cnt), 1);
        check({tag, "_keep_mask"}, 32'(err_mask), 32'(exp_mask));
        check({tag, "_keep_pass"}, 32'(pass), 32'(exp_mask == 8'h00));
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic reset_mid_run();
        int done_cnt = 0;
        @(negedge clk);
        a_in  = 8'd10;
        b_in  = 8'd10;
        start = 1'b1;
        for (int cyc = 1; cyc <= 3 * D + D / 2; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) start = 1'b0;
        end
        check("mid_alu_s", 32'(bus.alu_s), 3);
        check("mid_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 8 * D; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) rst_n = 1'b1;
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 0);
        check("midrst_idle", 32'(busy), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        a_in       = '0;
        b_in       = '0;
        fault_mode = 0;
        fault_op   = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("start_low_idle", 32'(busy), 0);

        run_seq(8'd10, 8'd10, 0, "a10b10");
        run_seq(8'd200, 8'd100, 0, "a200b100");
        run_seq(8'd100, 8'd200, 0, "a100b200");
        run_seq(8'h81, 8'($urandom), 0, "a81");
        run_seq(8'h00, 8'hFF, 0, "a00bff");

        fault_mode = 1;
        fault_op   = 2;
        run_seq(8'd10, 8'd10, 0, "stuck_and");
        fault_mode = 0;

        run_seq(8'd10, 8'd10, 15, "restart");

        reset_mid_run();
        run_seq(8'd10, 8'd10, 0, "after_rst");

        for (int i = 0; i < 12; i++) begin
            fault_mode = int'($urandom_range(0, 3));
            fault_op   = int'($urandom_range(0, 7));
            run_seq(8'($urandom), 8'($urandom), 0, $sformatf("rnd%0d", i));
        end
        fault_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
